// File: rtl/lc3b_types.sv
// Shared LC-3b types: the 16-bit machine word and the memory-arbiter FSM states.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of one shared memory port.
// Conflicts in IDLE are resolved round-robin against the previously granted port.
import lc3b_types::*;

module mem_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_read,
    input  lc3b_word   i_address,
    output lc3b_word   i_rdata,
    output logic       i_resp,
    input  logic       d_read,
    input  logic       d_write,
    input  logic [1:0] d_wmask,
    input  lc3b_word   d_address,
    input  lc3b_word   d_wdata,
    output lc3b_word   d_rdata,
    output logic       d_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    output lc3b_word   pmem_address,
    output lc3b_word   pmem_wdata,
    output logic [1:0] pmem_wmask,
    input  lc3b_word   pmem_rdata,
    input  logic       pmem_resp
);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;  // 1 = data port granted last
    lc3b_word   stall_cnt_q, stall_cnt_d;
    logic       d_req;

    assign d_req = d_read | d_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (i_read && d_req) begin
                    if (last_grant_q) begin
                        state_d      = SERVE_I;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = SERVE_D;
                        last_grant_d = 1'b1;
                    end
                end else if (i_read) begin
                    state_d      = SERVE_I;
                    last_grant_d = 1'b0;
                end else if (d_req) begin
                    state_d      = SERVE_D;
                    last_grant_d = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                // Hold until memory completes, even if the requester dropped out early.
                if (pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_read && !i_resp && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            stall_cnt_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 16'h0000;
        pmem_wmask   = 2'b00;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (state_q)
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address;
                i_resp       = pmem_resp;
            end
            SERVE_D: begin
                // A simultaneous read and write is issued as a write.
                pmem_read    = d_read & ~d_write;
                pmem_write   = d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                pmem_wmask   = d_wmask;
                d_resp       = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: each task drives one scenario and checks outputs inline.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_read = 1'b0;
    logic [15:0] i_address = 16'h0;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [1:0]  d_wmask = 2'b00;
    logic [15:0] d_address = 16'h0;
    logic [15:0] d_wdata = 16'h0;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_wmask;
    logic [15:0] pmem_rdata = 16'h0;
    logic        pmem_resp = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_wmask      (d_wmask),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_wmask   (pmem_wmask),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 1'b0; i_address = 16'h0;
        d_read = 1'b0; d_write = 1'b0; d_wmask = 2'b00;
        d_address = 16'h0; d_wdata = 16'h0;
        pmem_rdata = 16'h0; pmem_resp = 1'b0;
    endtask

    // Returns at a falling edge with rst_n just released and all inputs idle.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_read = 1'b1; d_write = 1'b1; pmem_resp = 1'b1;
        @(negedge clk);
        total++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
            $display("FAIL reset_outputs: got rd/wr/iresp/dresp=%b required 0000",
                     {pmem_read, pmem_write, i_resp, d_resp});
            bad++;
        end
        total++;
        if (dut.stall_cnt_q !== 16'h0000) begin
            $display("FAIL reset_stall_cnt: got %h required 0000", dut.stall_cnt_q);
            bad++;
        end
        $display("txn reset: outputs checked under reset");
    endtask

    task automatic test_i_read();
        do_reset();
        i_read = 1'b1; i_address = 16'h3000;
        #1;
        total++;
        if (pmem_read !== 1'b0) begin
            $display("FAIL iread_cycle0: got pmem_read=%b required 0", pmem_read);
            bad++;
        end
        for (int c = 1; c <= 2; c++) begin
            cyc();
            @(negedge clk);
            total++;
            if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h3000) begin
                $display("FAIL iread_cmd_c%0d: got rd=%b wr=%b addr=%h required 1 0 3000",
                         c, pmem_read, pmem_write, pmem_address);
                bad++;
            end
        end
        cyc();
        pmem_resp = 1'b1; pmem_rdata = 16'h1234;
        @(negedge clk);
        total++;
        if (i_resp !== 1'b1 || i_rdata !== 16'h1234 || d_resp !== 1'b0) begin
            $display("FAIL iread_resp: got iresp=%b idata=%h dresp=%b required 1 1234 0",
                     i_resp, i_rdata, d_resp);
            bad++;
        end
        cyc();
        i_read = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        total++;
        if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin
            $display("FAIL iread_done: got rd=%b iresp=%b required 0 0", pmem_read, i_resp);
            bad++;
        end
        total++;
        if (dut.stall_cnt_q !== 16'd3) begin
            $display("FAIL iread_stall_cnt: got %0d required 3", dut.stall_cnt_q);
            bad++;
        end
        $display("txn i_read 0x3000 -> 0x1234");
    endtask

    task automatic test_conflict();
        do_reset();
        i_read = 1'b1; i_address = 16'h3000;
        d_write = 1'b1; d_address = 16'h4000; d_wdata = 16'hBEEF; d_wmask = 2'b11;
        cyc();
        @(negedge clk);
        total++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h3000) begin
            $display("FAIL conflict_i_first: got rd=%b wr=%b addr=%h required 1 0 3000",
                     pmem_read, pmem_write, pmem_address);
            bad++;
        end
        #1 pmem_resp = 1'b1; pmem_rdata = 16'h0A0A;
        #1;
        total++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
            $display("FAIL conflict_i_resp: got iresp=%b dresp=%b required 1 0", i_resp, d_resp);
            bad++;
        end
        cyc();
        i_read = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        total++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            $display("FAIL conflict_gap: got rd=%b wr=%b required 0 0", pmem_read, pmem_write);
            bad++;
        end
        cyc();
        @(negedge clk);
        total++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h4000 ||
            pmem_wdata !== 16'hBEEF || pmem_wmask !== 2'b11) begin
            $display("FAIL conflict_d_cmd: got wr=%b rd=%b addr=%h wdata=%h mask=%b required 1 0 4000 beef 11",
                     pmem_write, pmem_read, pmem_address, pmem_wdata, pmem_wmask);
            bad++;
        end
        #1 pmem_resp = 1'b1;
        #1;
        total++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
            $display("FAIL conflict_d_resp: got dresp=%b iresp=%b required 1 0", d_resp, i_resp);
            bad++;
        end
        cyc();
        clear_inputs();
        $display("txn conflict: I 0x3000 then D write 0x4000/0xbeef");
    endtask

    task automatic test_round_robin();
        logic found;
        logic got_d;
        logic exp_d;
        do_reset();
        i_read = 1'b1; i_address = 16'h1000;
        d_read = 1'b1; d_address = 16'h2000;
        for (int n = 0; n < 6; n++) begin
            exp_d = n[0];
            found = 1'b0;
            for (int k = 0; k < 8 && !found; k++) begin
                @(negedge clk);
                if (pmem_read || pmem_write) found = 1'b1;
            end
            total++;
            if (!found) begin
                $display("FAIL rr_timeout_%0d: got no command in 8 cycles required a grant", n);
                bad++;
            end else begin
                got_d = (pmem_address == 16'h2000);
                if (got_d !== exp_d) begin
                    $display("FAIL rr_grant_%0d: got port %s required port %s", n,
                             got_d ? "D" : "I", exp_d ? "D" : "I");
                    bad++;
                end
                #1 pmem_resp = 1'b1;
                #1;
                total++;
                if (i_resp !== !exp_d || d_resp !== exp_d) begin
                    $display("FAIL rr_resp_%0d: got iresp=%b dresp=%b required %b %b",
                             n, i_resp, d_resp, !exp_d, exp_d);
                    bad++;
                end
                $display("txn rr %0d: grant %s", n, got_d ? "D" : "I");
                cyc();
                pmem_resp = 1'b0;
            end
        end
        clear_inputs();
    endtask

    task automatic test_rw_both();
        do_reset();
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h0010;
        d_wdata = 16'h5A5A; d_wmask = 2'b01;
        cyc();
        @(negedge clk);
        total++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h0010 ||
            pmem_wmask !== 2'b01) begin
            $display("FAIL rw_both_cmd: got wr=%b rd=%b addr=%h mask=%b required 1 0 0010 01",
                     pmem_write, pmem_read, pmem_address, pmem_wmask);
            bad++;
        end
        #1 pmem_resp = 1'b1;
        #1;
        total++;
        if (d_resp !== 1'b1) begin
            $display("FAIL rw_both_resp: got dresp=%b required 1", d_resp);
            bad++;
        end
        cyc();
        clear_inputs();
        $display("txn d_read+d_write 0x0010 issued as write");
    endtask

    task automatic test_early_drop();
        do_reset();
        i_read = 1'b1; i_address = 16'h0500;
        cyc();
        i_read = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (pmem_read !== 1'b1 || pmem_address !== 16'h0500) begin
                $display("FAIL early_drop_hold_%0d: got rd=%b addr=%h required 1 0500",
                         c, pmem_read, pmem_address);
                bad++;
            end
            if (c == 0) cyc();
        end
        #1 pmem_resp = 1'b1;
        #1;
        total++;
        if (i_resp !== 1'b1) begin
            $display("FAIL early_drop_resp: got iresp=%b required 1", i_resp);
            bad++;
        end
        cyc();
        pmem_resp = 1'b0;
        @(negedge clk);
        total++;
        if (pmem_read !== 1'b0) begin
            $display("FAIL early_drop_idle: got rd=%b required 0", pmem_read);
            bad++;
        end
        clear_inputs();
        $display("txn i_read dropped early, served to completion");
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_write = 1'b1; d_address = 16'h4000; d_wdata = 16'hBEEF; d_wmask = 2'b11;
        cyc();
        @(negedge clk);
        total++;
        if (pmem_write !== 1'b1) begin
            $display("FAIL rstmid_serve_d: got wr=%b required 1", pmem_write);
            bad++;
        end
        i_read = 1'b1; i_address = 16'h3000;
        #2 rst_n = 1'b0;
        pmem_resp = 1'b1;
        #1;
        total++;
        if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || d_resp !== 1'b0 || i_resp !== 1'b0) begin
            $display("FAIL rstmid_async: got wr=%b rd=%b dresp=%b iresp=%b required 0 0 0 0",
                     pmem_write, pmem_read, d_resp, i_resp);
            bad++;
        end
        total++;
        if (dut.state_q !== lc3b_types::IDLE) begin
            $display("FAIL rstmid_state: got %0d required IDLE", dut.state_q);
            bad++;
        end
        cyc();
        pmem_resp = 1'b0; d_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (pmem_read !== 1'b0) begin
            $display("FAIL rstmid_no_early_grant: got rd=%b required 0", pmem_read);
            bad++;
        end
        cyc();
        @(negedge clk);
        total++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h3000) begin
            $display("FAIL rstmid_i_grant: got rd=%b addr=%h required 1 3000", pmem_read, pmem_address);
            bad++;
        end
        #1 pmem_resp = 1'b1;
        cyc();
        clear_inputs();
        $display("txn reset during SERVE_D, pending i_read granted after release");
    endtask

    task automatic test_spurious();
        do_reset();
        pmem_resp = 1'b1; pmem_rdata = 16'hFFFF;
        #1;
        total++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
            $display("FAIL spurious_resp: got iresp=%b dresp=%b required 0 0", i_resp, d_resp);
            bad++;
        end
        cyc();
        @(negedge clk);
        total++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || dut.state_q !== lc3b_types::IDLE) begin
            $display("FAIL spurious_idle: got rd=%b wr=%b state=%0d required 0 0 IDLE",
                     pmem_read, pmem_write, dut.state_q);
            bad++;
        end
        clear_inputs();
        $display("txn spurious pmem_resp in IDLE ignored");
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_conflict();
        test_round_robin();
        test_rw_both();
        test_early_drop();
        test_reset_mid();
        test_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have no parameters; all 16-bit buses use lc3b_word from lc3b_types.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_read  input  1  instruction-port read request, held until i_resp.
REQ-005 i_address  input  16  instruction-port address.
REQ-006 i_rdata  output  16  instruction-port read data.
REQ-007 i_resp  output  1  instruction-port completion pulse.
REQ-008 d_read  input  1  data-port read request, held until d_resp.
REQ-009 d_write  input  1  data-port write request, held until d_resp.
REQ-010 d_wmask  input  2  data-port byte enables.
REQ-011 d_address  input  16  data-port address.
REQ-012 d_wdata  input  16  data-port write data.
REQ-013 d_rdata  output  16  data-port read data.
REQ-014 d_resp  output  1  data-port completion pulse.
REQ-015 pmem_read / pmem_write  output  1 each  shared-memory commands.
REQ-016 pmem_address  output  16; pmem_wdata  output  16; pmem_wmask  output  2.
REQ-017 pmem_rdata  input  16; pmem_resp  input  1  shared-memory data and completion.

Function
REQ-018 SHALL implement FSM states IDLE, SERVE_I, SERVE_D; reset state IDLE.
REQ-019 IDLE: no pmem command driven; i_resp = d_resp = 0.
REQ-020 IDLE, only i_read: next state SERVE_I; only d_read or d_write: next state SERVE_D.
REQ-021 IDLE, both ports requesting: grant the port NOT in last_grant (1-bit register, reset value D, so I wins first conflict).
REQ-022 last_grant SHALL update on every IDLE->SERVE_x transition.
REQ-023 SERVE_I: pmem_read=1, pmem_write=0, pmem_address=i_address; SERVE_D: pmem_read=d_read&~d_write, pmem_write=d_write, pmem_address=d_address, pmem_wdata=d_wdata, pmem_wmask=d_wmask.
REQ-024 d_read and d_write both high SHALL be treated as a write.
REQ-025 In SERVE_x with pmem_resp=1: x_resp=1 combinationally in the same cycle, x_rdata=pmem_rdata; next state IDLE.
REQ-026 i_rdata and d_rdata SHALL pass pmem_rdata at all times; validity indicated only by resp.
REQ-027 Grant latency: request seen in IDLE -> pmem command in the next cycle; minimum 2 cycles request-to-resp; one idle cycle between back-to-back grants.
REQ-028 Requester deasserting before resp (protocol violation): arbiter SHALL hold the state until pmem_resp, then return to IDLE; resp is still pulsed.
REQ-029 pmem_resp outside SERVE_x SHALL be ignored.
REQ-030 No port SHALL wait more than one foreign transaction once the other port is also requesting (round-robin guarantee).
REQ-031 stall_cnt (16-bit internal, saturating at 0xFFFF) SHALL count cycles i_read is high without i_resp; debug only, no port.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, last_grant=D, stall_cnt=0, and pmem_read=pmem_write=i_resp=d_resp=0, mid-transaction included.
REQ-033 After rst_n release, first grant SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-034 arb_state_t enum (IDLE, SERVE_I, SERVE_D) SHALL live in lc3b_types; no new constants.
REQ-035 Single module, no sub-module; state and last_grant in one always_ff, outputs in always_comb.

Verification
REQ-036 i_read only, i_address=0x3000, pmem_resp after 3 cycles with 0x1234 -> pmem_read=1 addr 0x3000 from cycle 1, i_resp pulse with i_rdata=0x1234, d_resp never.
REQ-037 i_read and d_write (addr 0x4000, data 0xBEEF, mask 2'b11) same cycle after reset -> I served first, then D with pmem_write=1, 0x4000/0xBEEF.
REQ-038 Both ports held continuously for 6 transactions -> grants alternate I,D,I,D,I,D.
REQ-039 d_read and d_write both high, addr 0x0010 -> pmem_write=1, pmem_read=0.
REQ-040 rst_n low in SERVE_D before pmem_resp -> pmem_write drops same cycle, state IDLE, no d_resp; after release, pending i_read granted.
REQ-041 Spurious pmem_resp in IDLE -> no resp pulse, state unchanged.
